truth_table_2_verilog_3inputs: RTL and testbench

//  Three-input Boolean function block driven by a programmable 8-entry truth table.
//  - Y: combinational function of (a,b,c).
//  - y_q: registered copy of Y.
//  - Truth table is writable at run time; its reset value is a parameter.
//  - Sits in the combinational-logic library as a generic 3-LUT for glue logic and bench checks.

---
 rtl/truth_table_2_verilog_3inputs.sv | 95 +++++++++
 tb/tb_truth_table_2_verilog_3inputs.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_2_verilog_3inputs.sv
// Programmable 3-input LUT: Y = tt_q[{a,b,c}] combinationally, y_q is Y one clock later.
// Optional input-coverage map is built only when TT_COV_EN is defined.
module truth_table_2_verilog_3inputs #(
  parameter logic [7:0] TT_INIT = 8'hE8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       Y,
  output logic       y_q,
  input  logic       tt_we,
  input  logic [7:0] tt_wdata,
  output logic [7:0] tt_q,
  input  logic       cov_clr,
  output logic [7:0] cov_map,
  output logic       cov_full
);

  logic [2:0] idx_s;
  logic [7:0] tt_d;
  logic       y_d;

  assign idx_s = {a, b, c};

  // Table lookup and next-state for the table and the registered result
  always_comb begin
    Y    = tt_q[idx_s];
    y_d  = Y;
    tt_d = tt_q;
    if (tt_we) begin
      tt_d = tt_wdata;
    end else begin
      tt_d = tt_q;
    end
  end

  // Table and result registers; reset restores the power-on function
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_q <= TT_INIT;
      y_q  <= 1'b0;
    end else begin
      tt_q <= tt_d;
      y_q  <= y_d;
    end
  end

`ifdef TT_COV_EN
  logic [7:0] cov_map_q;
  logic [7:0] cov_map_d;
  logic [7:0] hit_s;

  // One-hot decode of the sampled index; clear has priority over a same-edge hit
  always_comb begin
    hit_s = 8'h00;
    case (idx_s)
      3'd0:    hit_s = 8'h01;
      3'd1:    hit_s = 8'h02;
      3'd2:    hit_s = 8'h04;
      3'd3:    hit_s = 8'h08;
      3'd4:    hit_s = 8'h10;
      3'd5:    hit_s = 8'h20;
      3'd6:    hit_s = 8'h40;
      3'd7:    hit_s = 8'h80;
      default: hit_s = 8'h00;
    endcase
    if (cov_clr) begin
      cov_map_d = 8'h00;
    end else begin
      cov_map_d = cov_map_q | hit_s;
    end
  end

  // Sticky coverage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cov_map_q <= 8'h00;
    end else begin
      cov_map_q <= cov_map_d;
    end
  end

  assign cov_map  = cov_map_q;
  assign cov_full = (cov_map_q == 8'hFF);
`else
  logic unused_cov_clr;

  assign unused_cov_clr = cov_clr;
  assign cov_map        = 8'h00;
  assign cov_full       = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_2_verilog_3inputs.sv
// Scoreboard bench for truth_table_2_verilog_3inputs: stimulus queues expectations,
// a monitor process pops and compares them against the DUT outputs.
module tb_truth_table_2_verilog_3inputs;

  logic       clk;
  logic       rst;
  logic       a, b, c;
  logic       Y;
  logic       y_q;
  logic       tt_we;
  logic [7:0] tt_wdata;
  logic [7:0] tt_q;
  logic       cov_clr;
  logic [7:0] cov_map;
  logic       cov_full;

`ifdef TT_COV_EN
  localparam bit COV_ON = 1'b1;
`else
  localparam bit COV_ON = 1'b0;
`endif

  localparam int SEL_Y    = 0;
  localparam int SEL_YQ   = 1;
  localparam int SEL_TT   = 2;
  localparam int SEL_COV  = 3;
  localparam int SEL_FULL = 4;

  // Hand-computed function tables, index 0..7
  bit maj_y [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  bit par_y [0:7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } chk_t;

  chk_t sb_q[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  truth_table_2_verilog_3inputs dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .c        (c),
    .Y        (Y),
    .y_q      (y_q),
    .tt_we    (tt_we),
    .tt_wdata (tt_wdata),
    .tt_q     (tt_q),
    .cov_clr  (cov_clr),
    .cov_map  (cov_map),
    .cov_full (cov_full)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Queue an expectation and signal the monitor to compare now
  task automatic expect_val(input string tag, input int sel, input logic [7:0] exp);
    chk_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  task automatic set_abc(input int i);
    logic [2:0] v;
    v = i[2:0];
    {a, b, c} = v;
  endtask

  // Monitor: drain the scoreboard whenever the stimulus presents a sample point
  initial begin
    chk_t       e;
    logic [7:0] act;
    forever begin
      @(chk_ev);
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        case (e.sel)
          SEL_Y:    act = {7'd0, Y};
          SEL_YQ:   act = {7'd0, y_q};
          SEL_TT:   act = tt_q;
          SEL_COV:  act = cov_map;
          default:  act = {7'd0, cov_full};
        endcase
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h at %0t", e.tag, act, e.exp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] acc;
    rst = 1'b1; a = 1'b0; b = 1'b0; c = 1'b0;
    tt_we = 1'b0; tt_wdata = 8'h00; cov_clr = 1'b0;
    #5;
    expect_val("reset_tt", SEL_TT, 8'hE8);
    expect_val("reset_yq", SEL_YQ, 8'h00);
    expect_val("reset_cov", SEL_COV, 8'h00);
    expect_val("reset_full", SEL_FULL, 8'h00);
    n_cmp++;
    if (tt_q !== 8'hE8) begin
      n_bad++;
      $display("FAIL direct_reset_tt: got %h at %0t", tt_q, $time);
    end
    @(negedge clk);
    rst = 1'b0;

    // Test 1: sweep with majority table
    for (int i = 0; i < 8; i++) begin
      set_abc(i);
      #99;
      expect_val($sformatf("maj_Y_%0d", i), SEL_Y, {7'd0, maj_y[i]});
      expect_val($sformatf("maj_yq_%0d", i), SEL_YQ, {7'd0, maj_y[i]});
    end
    expect_val("maj_tt", SEL_TT, 8'hE8);
    expect_val("sweep_cov", SEL_COV, COV_ON ? 8'hFF : 8'h00);
    expect_val("sweep_full", SEL_FULL, {7'd0, COV_ON});
    n_cmp++;
    if (Y !== 1'b1) begin
      n_bad++;
      $display("FAIL direct_maj_Y7: got %b at %0t", Y, $time);
    end

    // Test 2: write parity table with {a,b,c}=011 to see edge-exact switching
    @(negedge clk);
    set_abc(3);
    @(negedge clk);
    expect_val("pre_wr_yq", SEL_YQ, 8'h01);
    tt_wdata = 8'h96; tt_we = 1'b1;
    @(posedge clk);
    #1;
    tt_we = 1'b0;
    expect_val("wr_Y_new", SEL_Y, 8'h00);
    expect_val("wr_yq_old", SEL_YQ, 8'h01);
    expect_val("wr_tt", SEL_TT, 8'h96);
    n_cmp++;
    if (tt_q !== 8'h96) begin
      n_bad++;
      $display("FAIL direct_wr_tt: got %h at %0t", tt_q, $time);
    end
    @(posedge clk);
    #1;
    expect_val("wr_yq_next", SEL_YQ, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_abc(i);
      #99;
      expect_val($sformatf("par_Y_%0d", i), SEL_Y, {7'd0, par_y[i]});
      expect_val($sformatf("par_yq_%0d", i), SEL_YQ, {7'd0, par_y[i]});
    end
    expect_val("par_tt", SEL_TT, 8'h96);

    // Test 4: asynchronous reset between edges, write during reset ignored
    @(posedge clk);
    #5;
    rst = 1'b1;
    #1;
    expect_val("arst_tt", SEL_TT, 8'hE8);
    expect_val("arst_yq", SEL_YQ, 8'h00);
    expect_val("arst_cov", SEL_COV, 8'h00);
    n_cmp++;
    if (y_q !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_arst_yq: got %b at %0t", y_q, $time);
    end
    tt_wdata = 8'h00; tt_we = 1'b1;
    @(posedge clk);
    #1;
    tt_we = 1'b0;
    expect_val("rst_we_ignored", SEL_TT, 8'hE8);
    set_abc(0);
    @(negedge clk);
    rst = 1'b0;

    // Test 3: hold 011 with default table
    @(negedge clk);
    set_abc(3);
    #1;
    expect_val("hold_Y", SEL_Y, 8'h01);
    expect_val("hold_yq0", SEL_YQ, 8'h00);
    @(posedge clk);
    #1;
    expect_val("hold_yq1", SEL_YQ, 8'h01);
    @(posedge clk);
    #1;
    expect_val("hold_yq2", SEL_YQ, 8'h01);

    // Test 5/6: coverage accumulation and clear
    @(negedge clk);
    rst = 1'b1;
    set_abc(0);
    @(negedge clk);
    rst = 1'b0;
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      set_abc(i);
      acc = acc | (8'h01 << i);
      @(posedge clk);
      #1;
      expect_val($sformatf("cov_step_%0d", i), SEL_COV, COV_ON ? acc : 8'h00);
      @(negedge clk);
    end
    expect_val("cov_full_set", SEL_FULL, {7'd0, COV_ON});
    n_cmp++;
    if (cov_full !== COV_ON) begin
      n_bad++;
      $display("FAIL direct_cov_full: got %b at %0t", cov_full, $time);
    end
    set_abc(5);
    cov_clr = 1'b1;
    @(posedge clk);
    #1;
    expect_val("cov_clr_map", SEL_COV, 8'h00);
    expect_val("cov_clr_full", SEL_FULL, 8'h00);
    n_cmp++;
    if (cov_map !== 8'h00) begin
      n_bad++;
      $display("FAIL direct_cov_clr: got %h at %0t", cov_map, $time);
    end
    @(negedge clk);
    cov_clr = 1'b0;
    @(posedge clk);
    #1;
    expect_val("cov_after_clr", SEL_COV, COV_ON ? 8'h20 : 8'h00);

    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
